// File: rtl/alu_unit.sv
// Multi-cycle 12-bit ALU feeding the accumulator: single-cycle ops plus an iterative shift-add multiply.
// Optional multiplier is built only when ALU_MUL_EN is defined; otherwise opcode 011 reports unsupported.
module alu_unit #(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [11:0]  in1,
    input  logic [N-1:0] in2,
    output logic [11:0]  alu_out,
    output logic         done,
    output logic         busy,
    output logic         z,
    output logic         ovf,
    output logic [1:0]   fsm_state
);

    // Handshake: start is sampled only in IDLE; done is a one-cycle strobe, busy covers the multiply.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] opb;
    logic [11:0] res;
    logic        res_ovf;
    logic [12:0] sum13;
    logic [11:0] out_nxt;
    logic        done_nxt, z_nxt, ovf_nxt;

    assign opb = in2[11:0];

    generate
        if (N > 12) begin : g_bus_hi
            logic unused_bus_hi;
            assign unused_bus_hi = ^in2[N-1:12];
        end
    endgenerate

`ifdef ALU_MUL_EN
    logic [23:0] mcand, mcand_nxt;
    logic [23:0] prod, prod_nxt, prod_acc;
    logic [11:0] mplr, mplr_nxt;
    logic [3:0]  cnt, cnt_nxt;
`endif

    always_comb begin
        res     = in1;
        res_ovf = 1'b0;
        sum13   = 13'd0;
        case (op)
            3'b000: res = opb;
            3'b001: begin
                sum13   = {1'b0, in1} + {1'b0, opb};
                res     = sum13[11:0];
                res_ovf = sum13[12];
            end
            3'b010: begin
                res     = in1 - opb;
                res_ovf = (in1 < opb);
            end
            // Reached only when no multiplier is built: flag the op as unsupported.
            3'b011: begin
                res     = in1;
                res_ovf = 1'b1;
            end
            3'b100: res = in1 & opb;
            3'b101: begin
                sum13   = {1'b0, in1} + 13'd1;
                res     = sum13[11:0];
                res_ovf = sum13[12];
            end
            3'b110: begin
                res     = in1 - 12'd1;
                res_ovf = (in1 == 12'd0);
            end
            default: begin
                res     = in1;
                res_ovf = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        out_nxt   = alu_out;
        z_nxt     = z;
        ovf_nxt   = ovf;
        done_nxt  = 1'b0;
`ifdef ALU_MUL_EN
        mcand_nxt = mcand;
        mplr_nxt  = mplr;
        prod_nxt  = prod;
        cnt_nxt   = cnt;
        prod_acc  = prod + (mplr[0] ? mcand : 24'd0);
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_MUL_EN
                    if (op == 3'b011) begin
                        mcand_nxt = {12'd0, in1};
                        mplr_nxt  = opb;
                        prod_nxt  = 24'd0;
                        cnt_nxt   = 4'd0;
                        state_nxt = S_MUL;
                    end else begin
                        out_nxt   = res;
                        z_nxt     = (res == 12'd0);
                        ovf_nxt   = res_ovf;
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end
`else
                    out_nxt   = res;
                    z_nxt     = (res == 12'd0);
                    ovf_nxt   = res_ovf;
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
`endif
                end
            end
            S_MUL: begin
`ifdef ALU_MUL_EN
                prod_nxt  = prod_acc;
                mcand_nxt = mcand << 1;
                mplr_nxt  = mplr >> 1;
                cnt_nxt   = cnt + 4'd1;
                // Fixed 12 iterations regardless of operand values.
                if (cnt == 4'd11) begin
                    out_nxt   = prod_acc[11:0];
                    z_nxt     = (prod_acc[11:0] == 12'd0);
                    ovf_nxt   = |prod_acc[23:12];
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            alu_out <= 12'd0;
            done    <= 1'b0;
            z       <= 1'b1;
            ovf     <= 1'b0;
`ifdef ALU_MUL_EN
            mcand   <= 24'd0;
            mplr    <= 12'd0;
            prod    <= 24'd0;
            cnt     <= 4'd0;
`endif
        end else begin
            state   <= state_nxt;
            alu_out <= out_nxt;
            done    <= done_nxt;
            z       <= z_nxt;
            ovf     <= ovf_nxt;
`ifdef ALU_MUL_EN
            mcand   <= mcand_nxt;
            mplr    <= mplr_nxt;
            prod    <= prod_nxt;
            cnt     <= cnt_nxt;
`endif
        end
    end

    assign busy      = (state == S_MUL);
    assign fsm_state = state;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, hand-written corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_alu_unit;
    localparam int N = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [11:0]  in1;
    logic [N-1:0] in2;
    logic [11:0]  alu_out;
    logic         done, busy, z, ovf;
    logic [1:0]   fsm_state;

    alu_unit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
        .alu_out(alu_out), .done(done), .busy(busy), .z(z), .ovf(ovf),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the opcode rules, using plain integer arithmetic.
    function automatic void model(input int o, input int a, input int b,
                                  output int r, output int f, output int lat, output int bcnt);
        int s;
        lat = 1; bcnt = 0; f = 0; r = 0;
        case (o)
            0: r = b;
            1: begin s = a + b; r = s % 4096; f = (s > 4095); end
            2: begin f = (a < b); r = (a - b + 4096) % 4096; end
            3: begin
                if (MUL_EN) begin
                    s = a * b; r = s % 4096; f = ((s / 4096) != 0); lat = 13; bcnt = 12;
                end else begin
                    r = a; f = 1;
                end
            end
            4: r = a & b;
            5: begin s = a + 1; r = s % 4096; f = (s > 4095); end
            6: begin f = (a == 0); r = (a + 4095) % 4096; end
            default: r = a;
        endcase
    endfunction

    // Caller is positioned just after a falling edge; returns just after the falling edge following done.
    task automatic exec(input logic [2:0] o, input logic [11:0] a, input logic [N-1:0] b,
                        output logic [11:0] r, output logic zz, output logic ff,
                        output int lat, output int bcnt, output logic done_after);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); in1 = 12'($urandom); in2 = N'($urandom);
        lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        r = alu_out; zz = z; ff = ovf;
        @(negedge clk);
        done_after = done;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [11:0]  a;
        logic [N-1:0] b;
        logic [11:0]  exp_out;
        logic         exp_z;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [11:0] r, prev;
        logic zz, ff, da;
        int lat, bcnt, dcount;
        int er, ef, el, eb;
        logic [2:0] ro;
        logic [11:0] ra;
        logic [N-1:0] rb;

        vecs[0]  = '{3'b001, 12'hFFF, 16'h0001, 12'h000, 1'b1, 1'b1};
        vecs[1]  = '{3'b010, 12'h005, 16'h0007, 12'hFFE, 1'b0, 1'b1};
        vecs[2]  = '{3'b000, 12'h321, 16'h1ABC, 12'hABC, 1'b0, 1'b0};
        vecs[3]  = '{3'b100, 12'hF0F, 16'h1234, 12'h204, 1'b0, 1'b0};
        vecs[4]  = '{3'b101, 12'hFFF, 16'h0000, 12'h000, 1'b1, 1'b1};
        vecs[5]  = '{3'b110, 12'h000, 16'h0000, 12'hFFF, 1'b0, 1'b1};
        vecs[6]  = '{3'b110, 12'h001, 16'h0000, 12'h000, 1'b1, 1'b0};
        vecs[7]  = '{3'b111, 12'h5A5, 16'h00FF, 12'h5A5, 1'b0, 1'b0};
`ifdef ALU_MUL_EN
        vecs[8]  = '{3'b011, 12'h040, 16'h0041, 12'h040, 1'b0, 1'b1};
        vecs[9]  = '{3'b011, 12'h012, 16'h0003, 12'h036, 1'b0, 1'b0};
        vecs[10] = '{3'b011, 12'hABC, 16'h0000, 12'h000, 1'b1, 1'b0};
`else
        vecs[8]  = '{3'b011, 12'h123, 16'h0045, 12'h123, 1'b0, 1'b1};
        vecs[9]  = '{3'b011, 12'h000, 16'h0003, 12'h000, 1'b1, 1'b1};
        vecs[10] = '{3'b011, 12'hABC, 16'h0000, 12'hABC, 1'b0, 1'b1};
`endif

        // Reset state
        rst = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
        @(negedge clk); @(negedge clk);
        check("reset alu_out", 32'(alu_out), 32'h000);
        check("reset z", 32'(z), 32'h1);
        check("reset ovf", 32'(ovf), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset state", 32'(fsm_state), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            exec(vecs[i].op, vecs[i].a, vecs[i].b, r, zz, ff, lat, bcnt, da);
            check($sformatf("vec%0d alu_out", i), 32'(r), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d z", i), 32'(zz), 32'(vecs[i].exp_z));
            check($sformatf("vec%0d ovf", i), 32'(ff), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d latency", i), 32'(lat),
                  (vecs[i].op == 3'b011 && MUL_EN) ? 32'd13 : 32'd1);
            check($sformatf("vec%0d busy cycles", i), 32'(bcnt),
                  (vecs[i].op == 3'b011 && MUL_EN) ? 32'd12 : 32'd0);
            check($sformatf("vec%0d done pulse", i), 32'(da), 32'h0);
        end

        // start during a busy/DONE period must be ignored
        prev = alu_out;
`ifdef ALU_MUL_EN
        start = 1'b1; op = 3'b011; in1 = 12'h012; in2 = 16'h0003;
        @(negedge clk);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            start = 1'($urandom_range(0, 1)); op = 3'($urandom); in1 = 12'($urandom); in2 = N'($urandom);
            @(negedge clk);
            check("busy hold alu_out", 32'(alu_out), 32'(prev));
            if (done) dcount++;
        end
        start = 1'b0;
        r = alu_out;
        for (int i = 0; i < 8; i++) begin
            if (done) begin dcount++; r = alu_out; end
            @(negedge clk);
        end
        check("ignored starts done count", 32'(dcount), 32'd1);
        check("ignored starts product", 32'(r), 32'h036);
        check("ignored starts ovf", 32'(ovf), 32'h0);
`else
        start = 1'b1; op = 3'b001; in1 = 12'h100; in2 = 16'h0023;
        @(negedge clk);
        dcount = done ? 1 : 0;
        start = 1'b1; op = 3'b000; in2 = 16'h0777;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        check("ignored starts done count", 32'(dcount), 32'd1);
        check("ignored starts result", 32'(alu_out), 32'h123);
`endif

        // Asynchronous reset between clock edges
`ifdef ALU_MUL_EN
        start = 1'b1; op = 3'b011; in1 = 12'h0AB; in2 = 16'h00CD;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid-mul busy", 32'(busy), 32'h1);
`endif
        #2 rst = 1'b1;
        #1;
        check("async rst alu_out", 32'(alu_out), 32'h000);
        check("async rst busy", 32'(busy), 32'h0);
        check("async rst done", 32'(done), 32'h0);
        check("async rst z", 32'(z), 32'h1);
        check("async rst state", 32'(fsm_state), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exec(3'b001, 12'h0F0, 16'h000F, r, zz, ff, lat, bcnt, da);
        check("post-rst add", 32'(r), 32'h0FF);
        check("post-rst add latency", 32'(lat), 32'd1);
        check("post-rst add ovf", 32'(ff), 32'h0);

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 12'($urandom_range(0, 4095));
            rb = N'($urandom);
            model(int'(ro), int'(ra), int'(rb[11:0]), er, ef, el, eb);
            exec(ro, ra, rb, r, zz, ff, lat, bcnt, da);
            check($sformatf("rnd%0d op%0d alu_out", i, ro), 32'(r), 32'(er));
            check($sformatf("rnd%0d op%0d z", i, ro), 32'(zz), (er == 0) ? 32'h1 : 32'h0);
            check($sformatf("rnd%0d op%0d ovf", i, ro), 32'(ff), 32'(ef));
            check($sformatf("rnd%0d op%0d latency", i, ro), 32'(lat), 32'(el));
            check($sformatf("rnd%0d op%0d busy cycles", i, ro), 32'(bcnt), 32'(eb));
            check($sformatf("rnd%0d op%0d done pulse", i, ro), 32'(da), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
# alu_unit

Multi-cycle 12-bit arithmetic unit sitting directly upstream of the accumulator. Takes operand A from the accumulator's ALU operand register and operand B from the low 12 bits of the shared data bus. Executes one operation per `start` handshake and returns a registered 12-bit result with a one-cycle `done` strobe; `done` drives the accumulator's ALU-load enable, and the result drives its ALU data input. Multiplication is iterative shift-add; all other operations complete in one cycle.

## Interface
- `N`, 12 — data bus width; only bits [11:0] are used; N ≥ 12.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request; sampled only in IDLE.
- `op`  in  3  — opcode, latched with `start`.
- `in1`  in  12  — operand A, from the accumulator ALU operand register.
- `in2`  in  N  — operand B, from the bus; [11:0] used.
- `alu_out`  out  12  — registered result; holds until the next completion.
- `done`  out  1  — one-cycle completion pulse; feeds the accumulator ALU-load enable.
- `busy`  out  1  — high while a multiply is in progress.
- `z`  out  1  — zero flag, registered with `alu_out`.
- `ovf`  out  1  — carry, borrow or overflow flag, registered with `alu_out`.

## Operation
- Opcodes:
  - 000 PASS: B.
  - 001 ADD: A+B; `ovf` = carry-out.
  - 010 SUB: A−B; `ovf` = borrow (A<B).
  - 011 MUL: A×B low 12 bits; `ovf` = (product[23:12] ≠ 0).
  - 100 AND: A&B.
  - 101 INC: A+1; `ovf` = carry.
  - 110 DEC: A−1; `ovf` = borrow.
  - 111 reserved: result A, `ovf` 0.
- All arithmetic is unsigned modulo 2^12. `z` = (result == 0).
- FSM states: IDLE, MUL, DONE.
  - IDLE + `start` + MUL opcode: latch A, B; clear the 24-bit product and the 4-bit iteration counter; go to MUL.
  - IDLE + `start` + any other opcode: compute result, register result and flags, set `done`; go to DONE.
  - MUL: each cycle, if multiplier bit0 = 1, add the shifted multiplicand to the product. Then shift the multiplicand left and the multiplier right, and increment the counter. At the 12th iteration, load `alu_out`, `z` and `ovf`, set `done`, and go to DONE.
  - DONE: clear `done`; go to IDLE unconditionally. `start` in DONE is ignored.
- `start` while `busy` is ignored and is not queued; `op`, `in1` and `in2` may change freely after the latch edge.
- `alu_out`, `z` and `ovf` change only on a completion edge.

## Timing
- Reset values: `alu_out` = 0, `done` = 0, `busy` = 0, `z` = 1, `ovf` = 0; state IDLE; counter 0.
- Single-cycle op, `start` sampled at edge k:
  - result and `done` are valid after edge k;
  - `done` clears at edge k+1;
  - the earliest next `start` is accepted at edge k+2.
- MUL, `start` sampled at edge k:
  - `busy` is high after edge k through edge k+12;
  - result and `done` are valid after edge k+12;
  - `busy` is low in the `done` cycle.
- Throughput: one op per 2 cycles; one MUL per 13 cycles.
- Reset asserted mid-MUL: aborts immediately; no `done`; all outputs return to reset values asynchronously.
- Operand B = 0 in MUL still takes the full 12 iterations (fixed latency).

## Configuration
- `ALU_MUL_EN`:
  - Defined: MUL is implemented as above (MUL state, 24-bit product, counter).
  - Undefined: no multiplier logic is built. Opcode 011 behaves as reserved: result A, `ovf` = 1 to flag an unsupported op, `done` after one cycle, `busy` never asserts.

## Test plan
- Reset, then ADD A=0xFFF, B=0x001 → `alu_out` 0x000, `z` 1, `ovf` 1, `done` high exactly one cycle after the start edge.
- SUB A=0x005, B=0x007 → `alu_out` 0xFFE, `ovf` 1, `z` 0; PASS B=0xABC with N=16, bus 0x1ABC → `alu_out` 0xABC.
- MUL A=0x040, B=0x041 (`ALU_MUL_EN` defined) → `busy` for 12 cycles, `done` at edge k+12, `alu_out` 0x040, `ovf` 1; MUL 0x012×0x003 → 0x036, `ovf` 0.
- `start` pulsed repeatedly during MUL with different op/operands → ignored; only the original product is reported, with a single `done`.
- Reset asserted at iteration 6 of a MUL → `busy` and `done` go 0 and `alu_out` goes 0 immediately; the next ADD after deassertion completes normally.
- Build without `ALU_MUL_EN`: MUL A=0x123 → `alu_out` 0x123, `ovf` 1, `done` after one cycle, `busy` never high.
